// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Holds the key FSM encoding, keypad geometry constants and the snapshot
// classifier (population count plus priority encoder) used by keypad_scanner.
package keypad_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;
    localparam int KEY_CODE_W = 4;

    // Column drive when nothing is being scanned: every column released.
    localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } key_state_t;

    typedef enum logic [1:0] {
        SNAP_NONE,
        SNAP_SINGLE,
        SNAP_MULTI
    } snap_class_t;

    typedef struct packed {
        snap_class_t             cls;
        logic [KEY_CODE_W-1:0]   idx;
    } snap_info_t;

    // Counts the pressed keys in a full-scan snapshot and reports the lowest
    // set index; idx is only meaningful when exactly one key is down.
    function automatic snap_info_t classify_snapshot(input logic [NUM_KEYS-1:0] snap);
        snap_info_t  info;
        int unsigned ones;
        ones     = 0;
        info.idx = '0;
        info.cls = SNAP_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (snap[i]) begin
                ones++;
                info.idx = KEY_CODE_W'(i);
            end
        end
        if (ones == 1) begin
            info.cls = SNAP_SINGLE;
        end else if (ones > 1) begin
            info.cls = SNAP_MULTI;
        end
        return info;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-ones so an idle (pulled-up) keypad is seen during reset.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst_x,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_ROWS-1:0] row_sync
);

    logic [NUM_ROWS-1:0] row_meta;

    // Double-register the rows to resolve metastability before use.
    always_ff @(posedge clk) begin
        if (rst_x) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, debounce and a
// single-key reporting FSM producing key_code / key_valid / key_held.
// Optional auto-repeat is enabled by defining KEYPAD_TYPEMATIC_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 8
`ifdef KEYPAD_TYPEMATIC_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 60,
    parameter int unsigned REPEAT_RATE    = 15
`endif
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_pkg::*;

    localparam int         DIV_W   = $clog2(SCAN_DIV);
    localparam logic [7:0] DEB_CNT = 8'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0]   row_sync;
    logic                  scan_active;
    logic [DIV_W-1:0]      div_cnt;
    logic [1:0]            col_idx;
    logic [NUM_KEYS-1:0]   snapshot;
    logic                  scan_done;
    logic                  div_tc;

    key_state_t            state, state_nxt;
    logic [KEY_CODE_W-1:0] cand, cand_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic [KEY_CODE_W-1:0] code_q, code_nxt;
    logic                  held_q, held_nxt;
    logic                  valid_q, valid_nxt;
    snap_info_t            snap_info;

`ifdef KEYPAD_TYPEMATIC_EN
    logic [15:0]           rep_cnt, rep_cnt_nxt;
    logic                  rep_first, rep_first_nxt;
    logic [15:0]           rep_target;
`endif

    keypad_sync u_sync (
        .clk      (clk),
        .rst_x    (rst_x),
        .row_in   (row_in),
        .row_sync (row_sync)
    );

    assign div_tc    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign col_out   = scan_active ? ~(4'b0001 << col_idx) : COL_IDLE;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

    // Column scan: hold each column for SCAN_DIV clocks, sample its rows at the
    // terminal count, and flag a completed scan after the last column.
    always_ff @(posedge clk) begin
        if (rst_x) begin
            scan_active <= 1'b0;
            div_cnt     <= '0;
            col_idx     <= 2'd0;
            snapshot    <= '0;
            scan_done   <= 1'b0;
        end else begin
            scan_active <= 1'b1;
            scan_done   <= 1'b0;
            if (scan_active) begin
                if (div_tc) begin
                    div_cnt <= '0;
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        snapshot[r*NUM_COLS + int'(col_idx)] <= ~row_sync[r];
                    end
                    col_idx <= col_idx + 2'd1;
                    if (col_idx == 2'd3) begin
                        scan_done <= 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    // Key FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst_x) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= 8'd0;
            code_q    <= '0;
            held_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt   <= 16'd0;
            rep_first <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            code_q    <= code_nxt;
            held_q    <= held_nxt;
            valid_q   <= valid_nxt;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt   <= rep_cnt_nxt;
            rep_first <= rep_first_nxt;
`endif
        end
    end

    // Next-state logic: debounce a single key into PRESSED and debounce its
    // release; only a completed scan can move the FSM.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        held_nxt  = held_q;
        valid_nxt = 1'b0;
        snap_info = classify_snapshot(snapshot);
`ifdef KEYPAD_TYPEMATIC_EN
        rep_cnt_nxt   = rep_cnt;
        rep_first_nxt = rep_first;
        rep_target    = rep_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE);
`endif
        if (scan_done) begin
            unique case (state)
                IDLE: begin
                    if (snap_info.cls == SNAP_SINGLE) begin
                        cand_nxt = snap_info.idx;
                        cnt_nxt  = 8'd1;
                        if (DEB_CNT == 8'd1) begin
                            state_nxt = PRESSED;
                            code_nxt  = snap_info.idx;
                            valid_nxt = 1'b1;
                            held_nxt  = 1'b1;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (snap_info.cls == SNAP_SINGLE && snap_info.idx == cand) begin
                        cnt_nxt = cnt + 8'd1;
                        if (cnt_nxt >= DEB_CNT) begin
                            state_nxt = PRESSED;
                            code_nxt  = cand;
                            valid_nxt = 1'b1;
                            held_nxt  = 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                PRESSED: begin
                    if (snapshot[code_q]) begin
`ifdef KEYPAD_TYPEMATIC_EN
                        if (rep_cnt + 16'd1 >= rep_target) begin
                            valid_nxt     = 1'b1;
                            rep_cnt_nxt   = 16'd0;
                            rep_first_nxt = 1'b0;
                        end else begin
                            rep_cnt_nxt = rep_cnt + 16'd1;
                        end
`endif
                    end else begin
                        cnt_nxt   = 8'd1;
                        state_nxt = RELEASE;
`ifdef KEYPAD_TYPEMATIC_EN
                        rep_cnt_nxt   = 16'd0;
                        rep_first_nxt = 1'b1;
`endif
                        if (DEB_CNT == 8'd1) begin
                            state_nxt = IDLE;
                            held_nxt  = 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    if (!snapshot[code_q]) begin
                        cnt_nxt = cnt + 8'd1;
                        if (cnt_nxt >= DEB_CNT) begin
                            state_nxt = IDLE;
                            held_nxt  = 1'b0;
                        end
                    end else begin
                        state_nxt = PRESSED;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_SCANS = 3.
// A behavioural keypad drives row_in from col_out; accepted presses are pushed
// to a scoreboard queue and popped whenever the DUT strobes key_valid.
// Define KEYPAD_TYPEMATIC_EN to also exercise auto-repeat (delay 4, rate 2).
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk   = 1'b0;
    logic        rst_x = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed = 16'h0000;
    logic [3:0]  expQ[$];
    int          testsRun    = 0;
    int          testsFailed = 0;

    always #5 clk = ~clk;

    // Ideal keypad: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
`ifdef KEYPAD_TYPEMATIC_EN
        ,
        .REPEAT_DELAY   (4),
        .REPEAT_RATE    (2)
`endif
    ) dut (
        .clk       (clk),
        .rst_x     (rst_x),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        pressed = keys;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the first negedge of a new scan (col_out just became 1110).
    task automatic waitScanStart();
        int guard;
        guard = 0;
        while (col_out !== 4'b0111 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        while (col_out !== 4'b1110 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checkOutput("scan_timeout", 16'(guard), 16'd0);
        end
    endtask

    task automatic holdScans(input int n);
        repeat (n) waitScanStart();
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected key.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", {15'd0, key_valid}, 16'd0);
            end else begin
                checkOutput("valid_code", {12'd0, key_code}, {12'd0, expQ.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] expCol;
        int         nValid;

        // Reset state
        rst_x = 1'b1;
        stepCycles(3);
        checkOutput("rst_col",   {12'd0, col_out},   16'h000f);
        checkOutput("rst_code",  {12'd0, key_code},  16'd0);
        checkOutput("rst_valid", {15'd0, key_valid}, 16'd0);
        checkOutput("rst_held",  {15'd0, key_held},  16'd0);
        rst_x = 1'b0;

        // Idle column rotation, two full scans
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            expCol = 4'b0001 << ((i / 4) % 4);
            checkOutput("idle_col", {12'd0, col_out}, {12'd0, ~expCol});
        end

        // Clean press of key 6, held 5 scans, then released 3 scans
        waitScanStart();
        applyStimulus(16'h0040);
        expQ.push_back(4'd6);
        holdScans(3);
        stepCycles(1);
        checkOutput("press_valid", {15'd0, key_valid}, 16'd1);
        checkOutput("press_code",  {12'd0, key_code},  16'd6);
        checkOutput("press_held",  {15'd0, key_held},  16'd1);
        stepCycles(1);
        checkOutput("press_strobe_len", {15'd0, key_valid}, 16'd0);
        holdScans(2);
        applyStimulus(16'h0000);
        holdScans(2);
        stepCycles(1);
        checkOutput("release_held_early", {15'd0, key_held}, 16'd1);
        holdScans(1);
        stepCycles(1);
        checkOutput("release_held", {15'd0, key_held}, 16'd0);
        checkOutput("release_code", {12'd0, key_code}, 16'd6);

        // Bounce: 2 scans on, 1 off, 3 on
        waitScanStart();
        applyStimulus(16'h0040);
        holdScans(2);
        applyStimulus(16'h0000);
        holdScans(1);
        applyStimulus(16'h0040);
        expQ.push_back(4'd6);
        holdScans(2);
        checkOutput("bounce_no_early0", {15'd0, key_valid}, 16'd0);
        stepCycles(1);
        checkOutput("bounce_no_early1", {15'd0, key_valid}, 16'd0);
        holdScans(1);
        stepCycles(1);
        checkOutput("bounce_valid", {15'd0, key_valid}, 16'd1);
        applyStimulus(16'h0000);
        holdScans(4);
        checkOutput("bounce_release", {15'd0, key_held}, 16'd0);

        // Two keys together from IDLE are ignored
        waitScanStart();
        applyStimulus(16'h0240);
        holdScans(4);
        stepCycles(1);
        checkOutput("multi_no_accept", {15'd0, key_held}, 16'd0);
        applyStimulus(16'h0000);
        holdScans(1);

        // Key 6 accepted first, then key 9 added
        applyStimulus(16'h0040);
        expQ.push_back(4'd6);
        holdScans(3);
        stepCycles(1);
        checkOutput("single_valid", {15'd0, key_valid}, 16'd1);
        applyStimulus(16'h0240);
        holdScans(3);
        stepCycles(1);
        checkOutput("add9_held", {15'd0, key_held}, 16'd1);
        checkOutput("add9_code", {12'd0, key_code}, 16'd6);

        // Reset pulse while PRESSED
        rst_x = 1'b1;
        stepCycles(1);
        checkOutput("midrst_col",   {12'd0, col_out},   16'h000f);
        checkOutput("midrst_held",  {15'd0, key_held},  16'd0);
        checkOutput("midrst_code",  {12'd0, key_code},  16'd0);
        checkOutput("midrst_valid", {15'd0, key_valid}, 16'd0);
        applyStimulus(16'h0000);
        rst_x = 1'b0;
        stepCycles(1);
        checkOutput("restart_col0", {12'd0, col_out}, 16'h000e);

        // Long hold of key 6: 12 scans after acceptance
`ifdef KEYPAD_TYPEMATIC_EN
        nValid = 6;
`else
        nValid = 1;
`endif
        waitScanStart();
        applyStimulus(16'h0040);
        for (int i = 0; i < nValid; i++) begin
            expQ.push_back(4'd6);
        end
        holdScans(3);
        holdScans(12);
        stepCycles(2);
        checkOutput("long_held", {15'd0, key_held}, 16'd1);
        applyStimulus(16'h0000);
        holdScans(4);
        checkOutput("long_release", {15'd0, key_held}, 16'd0);

        checkOutput("sb_drained", 16'(expQ.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
